// File: rtl/mips_mem_pkg.sv
// Shared types for the data-side posted-write buffer: entry layout and drain FSM states.
package mips_mem_pkg;

  localparam int WORD_ADDR_W = 30;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] word_addr;
    logic [3:0][7:0]        data;
  } wbuf_entry_t;

  typedef enum logic {
    IDLE,
    REQ
  } wbuf_state_e;

endpackage

// File: rtl/wbuf_match.sv
// Word-address comparator across the occupied FIFO slots; the newest match (closest to tail) wins.
module wbuf_match
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [WORD_ADDR_W-1:0]     addrs [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       skip_head,
  input  logic [WORD_ADDR_W-1:0]     key,
  output logic                       hit,
  output logic [$clog2(DEPTH)-1:0]   sel
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] idx;

  // Walk from oldest to newest so later matches overwrite earlier ones.
  always_comb begin
    hit = 1'b0;
    sel = head;
    idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && !(skip_head && (i == 0)) && (addrs[idx] == key)) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer: queues core stores, drains them in order over req/ack, forwards newest data to loads.
// Optional in-place merging of stores into queued non-head entries is enabled by WBUF_MERGE_EN.
module mem_write_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data [0:3],
  output logic              full,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit,
  output logic [7:0]        rd_data [0:3],
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data [0:3],
  input  logic              mem_ack,
  input  logic              halted,
  output logic              empty,
  output logic              drained
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wbuf_entry_t              ent      [DEPTH];
  logic [WORD_ADDR_W-1:0]   ent_addr [DEPTH];
  logic [PTR_W-1:0]         head, tail, rd_sel, merge_sel, wr_idx;
  logic [CNT_W-1:0]         count, count_nxt;
  wbuf_state_e              state, state_nxt;
  logic [WORD_ADDR_W-1:0]   wr_word, rd_word;
  logic [3:0][7:0]          wr_dat;
  logic                     merge_hit, push, merge_wr, pop;
  logic                     unused_low_bits;

  assign wr_word         = WORD_ADDR_W'(wr_addr[ADDR_W-1:2]);
  assign rd_word         = WORD_ADDR_W'(rd_addr[ADDR_W-1:2]);
  assign unused_low_bits = ^{wr_addr[1:0], rd_addr[1:0]};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_addr[i] = ent[i].word_addr;
    for (int b = 0; b < 4; b++) wr_dat[b] = wr_data[b];
  end

  wbuf_match #(.DEPTH(DEPTH)) u_rd_match (
    .addrs(ent_addr), .head(head), .count(count), .skip_head(1'b0),
    .key(rd_word), .hit(rd_hit), .sel(rd_sel)
  );

`ifdef WBUF_MERGE_EN
  // The head may be mid-handshake, so it is never a merge target.
  wbuf_match #(.DEPTH(DEPTH)) u_wr_match (
    .addrs(ent_addr), .head(head), .count(count), .skip_head(1'b1),
    .key(wr_word), .hit(merge_hit), .sel(merge_sel)
  );
`else
  assign merge_hit = 1'b0;
  assign merge_sel = tail;
`endif

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign drained  = halted && empty;
  assign mem_req  = (state == REQ);
  assign push     = wr_en && !full && !merge_hit;
  assign merge_wr = wr_en && merge_hit;
  assign pop      = mem_req && mem_ack;
  assign wr_idx   = merge_wr ? merge_sel : tail;
  assign mem_addr = mem_req ? ADDR_W'({ent[head].word_addr, 2'b00}) : '0;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      rd_data[b]  = rd_hit  ? ent[rd_sel].data[b] : 8'h00;
      mem_data[b] = mem_req ? ent[head].data[b]   : 8'h00;
    end
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count_nxt != '0) state_nxt = REQ;
      REQ:     if (pop && (count_nxt == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count_nxt;
      state <= state_nxt;
    end
  end

  // Payload storage needs no reset: slots are only observed while counted as occupied.
  always_ff @(posedge clk) begin
    if (push || merge_wr) begin
      ent[wr_idx].word_addr <= wr_word;
      ent[wr_idx].data      <= wr_dat;
    end
  end

  wr_drop_chk: assert property (@(posedge clk) disable iff (!rst_b) !(wr_en && full && !merge_hit))
    else $warning("mem_write_buffer: store dropped while buffer full");

endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: queue-based reference model checked every cycle, directed cases plus random traffic.
// Expectations follow the build's WBUF_MERGE_EN setting.
module tb_mem_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_b, wr_en, full, rd_hit, mem_req, mem_ack, halted, empty, drained;
  logic [ADDR_W-1:0] wr_addr, rd_addr, mem_addr;
  logic [7:0]        wr_data [0:3];
  logic [7:0]        rd_data [0:3];
  logic [7:0]        mem_data [0:3];
  logic [31:0]       wr_w, rd_w, mem_w;

  int n_chk  = 0;
  int n_fail = 0;

  logic [29:0] q_addr [$];
  logic [31:0] q_data [$];

  always #5 clk = ~clk;

  assign wr_w  = {wr_data[3], wr_data[2], wr_data[1], wr_data[0]};
  assign rd_w  = {rd_data[3], rd_data[2], rd_data[1], rd_data[0]};
  assign mem_w = {mem_data[3], mem_data[2], mem_data[1], mem_data[0]};

  mem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .full(full), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .halted(halted), .empty(empty), .drained(drained)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wd(input logic [31:0] v);
    for (int b = 0; b < 4; b++) wr_data[b] = v[8*b +: 8];
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; set_wd(d);
    cyc();
    wr_en = 1'b0;
  endtask

  function automatic int merge_slot(input logic [29:0] w);
    int mi = -1;
`ifdef WBUF_MERGE_EN
    for (int j = 1; j < q_addr.size(); j++) if (q_addr[j] == w) mi = j;
`endif
    return mi;
  endfunction

  // Reference model: buffer contents as a plain ordered list.
  int  m_mi;
  bit  m_pop, m_push;
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q_addr.delete();
      q_data.delete();
    end else begin
      m_mi   = wr_en ? merge_slot(wr_addr[31:2]) : -1;
      m_pop  = mem_ack && (q_addr.size() > 0);
      m_push = wr_en && (m_mi < 0) && (q_addr.size() < DEPTH);
      if (m_mi >= 0) q_data[m_mi] = wr_w;
      if (m_pop) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (m_push) begin
        q_addr.push_back(wr_addr[31:2]);
        q_data.push_back(wr_w);
      end
    end
  end

  logic        e_hit;
  logic [31:0] e_rd;
  always @(negedge clk) begin
    e_hit = 1'b0;
    e_rd  = '0;
    for (int j = 0; j < q_addr.size(); j++)
      if (q_addr[j] == rd_addr[31:2]) begin e_hit = 1'b1; e_rd = q_data[j]; end
    chk("full",     {31'd0, full},    {31'd0, q_addr.size() == DEPTH});
    chk("empty",    {31'd0, empty},   {31'd0, q_addr.size() == 0});
    chk("drained",  {31'd0, drained}, {31'd0, halted && (q_addr.size() == 0)});
    chk("mem_req",  {31'd0, mem_req}, {31'd0, q_addr.size() > 0});
    chk("mem_addr", mem_addr, (q_addr.size() > 0) ? {q_addr[0], 2'b00} : 32'd0);
    chk("mem_data", mem_w,    (q_addr.size() > 0) ? q_data[0] : 32'd0);
    chk("rd_hit",   {31'd0, rd_hit},  {31'd0, e_hit});
    chk("rd_data",  rd_w, e_rd);
  end

  logic [31:0] x_addr [4];
  logic [31:0] x_data [4];
  int          x_n;
  logic [31:0] ra;

  initial begin
    rst_b = 1'b0; wr_en = 1'b0; wr_addr = '0; rd_addr = '0; mem_ack = 1'b0; halted = 1'b0;
    set_wd(32'h0);
    repeat (2) cyc();
    chk("rst_full",    {31'd0, full},    32'd0);
    chk("rst_empty",   {31'd0, empty},   32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rd_hit",  {31'd0, rd_hit},  32'd0);
    chk("rst_rd_data", rd_w, 32'd0);
    rst_b = 1'b1;
    cyc();

    // Single store, presented one cycle after the push edge.
    rd_addr = 32'h12;
    push(32'h10, 32'hDEADBEEF);
    chk("t1_req",     {31'd0, mem_req}, 32'd1);
    chk("t1_addr",    mem_addr, 32'h10);
    chk("t1_data",    mem_w, 32'hDEADBEEF);
    chk("t1_fwd_hit", {31'd0, rd_hit}, 32'd1);
    chk("t1_fwd",     rd_w, 32'hDEADBEEF);
    repeat (2) cyc();
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
    chk("t1_empty", {31'd0, empty}, 32'd1);

    // Fill to full, drop a fifth store, then drain back-to-back.
    for (int i = 0; i < 4; i++) push(32'(i * 4), 32'hA0000000 + 32'(i));
    chk("t2_full", {31'd0, full}, 32'd1);
    push(32'h30, 32'h55555555);
    chk("t2_model_size", 32'(q_addr.size()), 32'd4);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_addr", mem_addr, 32'(i * 4));
      chk("t2_drain_data", mem_w, 32'hA0000000 + 32'(i));
      cyc();
    end
    mem_ack = 1'b0;
    chk("t2_empty", {31'd0, empty}, 32'd1);

    // Duplicate address: the newest value is forwarded.
    rd_addr = 32'h22;
    push(32'h20, 32'h11111111);
    push(32'h20, 32'h22222222);
    chk("t3_hit",  {31'd0, rd_hit}, 32'd1);
    chk("t3_data", rd_w, 32'h22222222);
    mem_ack = 1'b1; repeat (2) cyc(); mem_ack = 1'b0;
    chk("t3_empty", {31'd0, empty}, 32'd1);

    // Push and pop in the same cycle with two queued.
    push(32'h40, 32'hAAAA0000);
    push(32'h44, 32'hBBBB0000);
    mem_ack = 1'b1;
    push(32'h48, 32'hCCCC0000);
    mem_ack = 1'b0;
    chk("t4_size", 32'(q_addr.size()), 32'd2);
    chk("t4_head", mem_addr, 32'h44);
    mem_ack = 1'b1; cyc();
    chk("t4_next", mem_addr, 32'h48);
    chk("t4_ndat", mem_w, 32'hCCCC0000);
    cyc(); mem_ack = 1'b0;
    chk("t4_empty", {31'd0, empty}, 32'd1);

    // Store to a queued non-head word, then to the in-flight head word.
    push(32'h0, 32'h01010101);
    push(32'h4, 32'h02020202);
    push(32'h4, 32'h03030303);
    push(32'h0, 32'h04040404);
    rd_addr = 32'h4; #1;
    chk("t5_fwd", rd_w, 32'h03030303);
`ifdef WBUF_MERGE_EN
    x_n = 3;
    x_addr = '{32'h0, 32'h4, 32'h0, 32'h0};
    x_data = '{32'h01010101, 32'h03030303, 32'h04040404, 32'h0};
`else
    x_n = 4;
    x_addr = '{32'h0, 32'h4, 32'h4, 32'h0};
    x_data = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
`endif
    mem_ack = 1'b1;
    for (int i = 0; i < x_n; i++) begin
      chk("t5_drain_addr", mem_addr, x_addr[i]);
      chk("t5_drain_data", mem_w, x_data[i]);
      cyc();
    end
    mem_ack = 1'b0;
    chk("t5_empty", {31'd0, empty}, 32'd1);

    // Halted core waits for the last acknowledged write.
    halted = 1'b1;
    push(32'h100, 32'h1);
    push(32'h104, 32'h2);
    push(32'h108, 32'h3);
    for (int k = 0; k < 3; k++) begin
      chk("t6_not_drained", {31'd0, drained}, 32'd0);
      mem_ack = 1'b1; cyc(); mem_ack = 1'b0; cyc();
    end
    chk("t6_drained", {31'd0, drained}, 32'd1);
    halted = 1'b0; #1;
    chk("t6_unhalted", {31'd0, drained}, 32'd0);

    // Asynchronous reset in the middle of a request.
    push(32'h200, 32'h5);
    push(32'h204, 32'h6);
    #2 rst_b = 1'b0;
    #1;
    chk("t6_rst_req",   {31'd0, mem_req}, 32'd0);
    chk("t6_rst_empty", {31'd0, empty},   32'd1);
    cyc();
    rst_b = 1'b1;
    cyc();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      ra      = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      wr_addr = ra;
      wr_en   = ($urandom % 2 == 0) && ((q_addr.size() < DEPTH) || (merge_slot(ra[31:2]) >= 0));
      set_wd($urandom);
      mem_ack = ($urandom % 10) < 4;
      rd_addr = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      halted  = ($urandom % 4) == 0;
      rst_b   = (c % 500) != 499;
      cyc();
    end
    rst_b = 1'b1; wr_en = 1'b0; mem_ack = 1'b0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
